// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-to-CSR bridge: FSM encoding and header layout.
package spi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  // Header bit selecting a write (1) or read (0) frame
  localparam int unsigned WR_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the raw SPI pins into clk and flags sample/shift edges of sck.
module spi_edge_sync #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sck,
  input  logic nss,
  input  logic sdi,
  output logic nss_s,
  output logic sdi_s,
  output logic settled,
  output logic sample_c,
  output logic shift_c
);

  logic [1:0] sck_sy;
  logic [1:0] nss_sy;
  logic [1:0] sdi_sy;
  logic       sck_q;
  logic [1:0] settle_q;
  logic       lead;
  logic       trail;

  // Two-flop synchronisers plus a delayed sck copy for edge detection; settle_q
  // marks when the nss pipeline carries pin values rather than reset values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sy   <= {2{CPOL}};
      nss_sy   <= 2'b11;
      sdi_sy   <= 2'b00;
      sck_q    <= CPOL;
      settle_q <= 2'b00;
    end else begin
      sck_sy   <= {sck_sy[0], sck};
      nss_sy   <= {nss_sy[0], nss};
      sdi_sy   <= {sdi_sy[0], sdi};
      sck_q    <= sck_sy[1];
      settle_q <= {settle_q[0], 1'b1};
    end
  end

  assign nss_s   = nss_sy[1];
  assign sdi_s   = sdi_sy[1];
  assign settled = settle_q[1];

  // Leading edge leaves the idle level, trailing edge returns to it
  assign lead     = (sck_q == CPOL) && (sck_sy[1] != CPOL);
  assign trail    = (sck_q != CPOL) && (sck_sy[1] == CPOL);
  assign sample_c = CPHA ? trail : lead;
  assign shift_c  = CPHA ? lead : trail;

endmodule

// File: rtl/spi_csr_bridge.sv
// SPI slave that turns header + data bytes into single-cycle CSR read/write strobes.
module spi_csr_bridge
  import spi_pkg::*;
#(
  parameter int unsigned A_WIDTH  = 5,
  parameter bit          CPOL     = 1'b0,
  parameter bit          CPHA     = 1'b0,
  parameter bit          AUTO_INC = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sck,
  input  logic               nss,
  input  logic               sdi,
  output logic               sdo,
  output logic               sdo_en,
  output logic               chip_select,
  output logic [A_WIDTH-1:0] csr_address,
  output logic               csr_read,
  output logic               csr_write,
  output logic [BYTE_W-1:0]  csr_writedata,
  input  logic [BYTE_W-1:0]  csr_readdata,
  output logic               frame_abort
);

  logic nss_s, sdi_s, settled, sample_c, shift_c;

  spi_edge_sync #(.CPOL(CPOL), .CPHA(CPHA)) u_edge_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .sck      (sck),
    .nss      (nss),
    .sdi      (sdi),
    .nss_s    (nss_s),
    .sdi_s    (sdi_s),
    .settled  (settled),
    .sample_c (sample_c),
    .shift_c  (shift_c)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  rx_q, rx_d;
  logic [BYTE_W-1:0]  tx_q, tx_d;
  logic               bit_q, bit_d;
  logic               wr_frame_q, wr_frame_d;
  logic               armed_q, armed_d;
  logic               rd_pend_q, rd_pend_d;
  logic [A_WIDTH-1:0] addr_d;
  logic [BYTE_W-1:0]  wdata_d;
  logic               rd_d, wr_d, abort_d, cs_d, sdo_en_d, sdo_d;
  logic [BYTE_W-1:0]  byte_in;

  // Next-state, datapath and strobe decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    bit_d      = bit_q;
    wr_frame_d = wr_frame_q;
    armed_d    = armed_q;
    rd_pend_d  = csr_read;
    addr_d     = csr_address;
    wdata_d    = csr_writedata;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    abort_d    = 1'b0;
    byte_in    = {rx_q[BYTE_W-2:0], sdi_s};

    // Post-increment after every strobe so reads prefetch the next byte
    if (AUTO_INC && (csr_read || csr_write)) begin
      addr_d = csr_address + A_WIDTH'(1);
    end

    // Read data arrives the cycle after csr_read; CPHA=0 presents bit7 at once
    if (rd_pend_q) begin
      if (CPHA) begin
        tx_d = csr_readdata;
      end else begin
        bit_d = csr_readdata[BYTE_W-1];
        tx_d  = {csr_readdata[BYTE_W-2:0], 1'b0};
      end
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Arm only after nss is seen high, so a frame cut by reset is skipped
        if (nss_s) begin
          if (settled) armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER, ST_DATA: begin
        if (nss_s) begin
          // nss rise beats a coincident 8th sample edge: the byte is dropped
          state_d = ST_IDLE;
          cnt_d   = '0;
          abort_d = (cnt_q != '0);
        end else begin
          if (sample_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            rx_d  = byte_in;
            if (cnt_q == CNT_W'(7)) begin
              if (state_q == ST_HEADER) begin
                state_d    = ST_DATA;
                wr_frame_d = byte_in[WR_BIT];
                addr_d     = byte_in[A_WIDTH-1:0];
                rd_d       = ~byte_in[WR_BIT];
              end else if (wr_frame_q) begin
                wr_d    = 1'b1;
                wdata_d = byte_in;
              end else begin
                rd_d = 1'b1;
              end
            end
          end
          // CPHA=0 holds the preloaded bit7 across the byte boundary edge
          if (shift_c && (state_q == ST_DATA) && !wr_frame_q &&
              (CPHA || (cnt_q != '0))) begin
            bit_d = tx_q[BYTE_W-1];
            tx_d  = {tx_q[BYTE_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cs_d     = ~nss_s;
    sdo_en_d = (state_d == ST_DATA) && !wr_frame_d && cs_d;
    sdo_d    = sdo_en_d & bit_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      bit_q         <= 1'b0;
      wr_frame_q    <= 1'b0;
      armed_q       <= 1'b0;
      rd_pend_q     <= 1'b0;
      csr_address   <= '0;
      csr_writedata <= '0;
      csr_read      <= 1'b0;
      csr_write     <= 1'b0;
      frame_abort   <= 1'b0;
      chip_select   <= 1'b0;
      sdo_en        <= 1'b0;
      sdo           <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      bit_q         <= bit_d;
      wr_frame_q    <= wr_frame_d;
      armed_q       <= armed_d;
      rd_pend_q     <= rd_pend_d;
      csr_address   <= addr_d;
      csr_writedata <= wdata_d;
      csr_read      <= rd_d;
      csr_write     <= wr_d;
      frame_abort   <= abort_d;
      chip_select   <= cs_d;
      sdo_en        <= sdo_en_d;
      sdo           <= sdo_d;
    end
  end

endmodule

// File: tb/tb_spi_csr_bridge.sv
// Scoreboard bench: an SPI master drives frames, a frame-level model predicts
// CSR strobes, aborts and returned bytes; a monitor compares as they appear.
module tb_spi_csr_bridge;

  localparam int H = 6;

  typedef struct {
    int inst;
    int addr;
    int data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic m_sck, m_nss, m_sdi;
  int   sel;

  logic       sck0, nss0, sck1, nss1;
  logic       sdo0, sdo_en0, cs0, rd0, wr0, ab0;
  logic       sdo1, sdo_en1, cs1, rd1, wr1, ab1;
  logic [4:0] addr0, addr1;
  logic [7:0] wd0, wd1;
  logic [7:0] rdata0 = 8'h00;
  logic [7:0] rdata1 = 8'h00;

  assign sck0 = (sel == 0) ? m_sck : 1'b0;
  assign nss0 = (sel == 0) ? m_nss : 1'b1;
  assign sck1 = (sel == 1) ? m_sck : 1'b1;
  assign nss1 = (sel == 1) ? m_nss : 1'b1;

  spi_csr_bridge #(.A_WIDTH(5), .CPOL(0), .CPHA(0), .AUTO_INC(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .sck(sck0), .nss(nss0), .sdi(m_sdi),
    .sdo(sdo0), .sdo_en(sdo_en0), .chip_select(cs0), .csr_address(addr0),
    .csr_read(rd0), .csr_write(wr0), .csr_writedata(wd0),
    .csr_readdata(rdata0), .frame_abort(ab0));

  spi_csr_bridge #(.A_WIDTH(5), .CPOL(1), .CPHA(1), .AUTO_INC(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .sck(sck1), .nss(nss1), .sdi(m_sdi),
    .sdo(sdo1), .sdo_en(sdo_en1), .chip_select(cs1), .csr_address(addr1),
    .csr_read(rd1), .csr_write(wr1), .csr_writedata(wd1),
    .csr_readdata(rdata1), .frame_abort(ab1));

  // CSR slave: register contents are address + 0x40
  always @(negedge clk) begin
    if (rd0) rdata0 = 8'((int'(addr0) + 64) % 256);
    if (rd1) rdata1 = 8'((int'(addr1) + 64) % 256);
  end

  ev_t        exp_wr[$];
  ev_t        exp_rd[$];
  int         exp_ab[$];
  int         exp_sdo[$];
  int         got_sdo[$];
  logic [7:0] frm[$];
  int         checks = 0;
  int         errors = 0;
  int         viol = 0;
  bit         en_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input int inst);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event on instance %0d at %0t", name, inst, $time);
  endtask

  task automatic mon(input int inst, input logic wr, input logic rd, input logic ab,
                     input logic so, input logic en, input logic [4:0] a,
                     input logic [7:0] d);
    ev_t e;
    int  ai;
    if (wr) begin
      if (exp_wr.size() == 0) unexpected("csr_write", inst);
      else begin
        e = exp_wr.pop_front();
        chk("write_inst", inst, e.inst);
        chk("write_addr", a, e.addr);
        chk("write_data", d, e.data);
      end
    end
    if (rd) begin
      if (exp_rd.size() == 0) unexpected("csr_read", inst);
      else begin
        e = exp_rd.pop_front();
        chk("read_inst", inst, e.inst);
        chk("read_addr", a, e.addr);
      end
    end
    if (ab) begin
      if (exp_ab.size() == 0) unexpected("frame_abort", inst);
      else begin
        ai = exp_ab.pop_front();
        chk("abort_inst", inst, ai);
      end
    end
    if (!en && so) viol++;
    if (rd && wr) viol++;
    if (en) en_seen = 1'b1;
  endtask

  // Monitor: compare every DUT strobe and every byte the master received
  always @(negedge clk) begin
    int g;
    if (reset_n) begin
      mon(0, wr0, rd0, ab0, sdo0, sdo_en0, addr0, wd0);
      mon(1, wr1, rd1, ab1, sdo1, sdo_en1, addr1, wd1);
      if (got_sdo.size() > 0) begin
        g = got_sdo.pop_front();
        if (exp_sdo.size() == 0) unexpected("sdo_byte", sel);
        else chk("sdo_byte", g, exp_sdo.pop_front());
      end
    end
  end

  task automatic wait_h();
    repeat (H) @(negedge clk);
  endtask

  task automatic set_sel(input int s);
    m_nss = 1'b1;
    m_sck = (s == 1);
    sel   = s;
    repeat (6) @(negedge clk);
  endtask

  // One SPI bit in the active instance's mode; col raises nss on the sample edge
  task automatic m_bit(input logic b, input bit col, output logic so);
    if (sel == 0) begin
      m_sdi = b;
      wait_h();
      m_sck = 1'b1;
      if (col) m_nss = 1'b1;
      so = sdo0;
      wait_h();
      m_sck = 1'b0;
    end else begin
      m_sck = 1'b0;
      m_sdi = b;
      wait_h();
      m_sck = 1'b1;
      if (col) m_nss = 1'b1;
      so = sdo1;
      wait_h();
    end
  endtask

  // Frame-level reference: eff = number of bits the bridge accepts
  task automatic model(input int s, input int eff);
    int hdr, a, nd;
    if (eff >= 8) begin
      hdr = int'(frm[0]);
      a   = hdr % 32;
      nd  = (eff - 8) / 8;
      if (hdr >= 128) begin
        for (int i = 0; i < nd; i++) begin
          exp_wr.push_back('{s, a, int'(frm[1+i])});
          if (s == 0) a = (a + 1) % 32;
        end
      end else begin
        for (int i = 0; i <= nd; i++) begin
          exp_rd.push_back('{s, a, 0});
          if (i < nd) exp_sdo.push_back((a + 64) % 256);
          if (s == 0) a = (a + 1) % 32;
        end
      end
    end
    if (eff % 8 != 0) exp_ab.push_back(s);
  endtask

  task automatic run_frame(input int nbits, input bit collide);
    int         eff;
    logic       so;
    logic [7:0] rxb, cur, h0;
    eff = collide ? nbits - 1 : nbits;
    h0  = frm[0];
    model(sel, eff);
    en_seen = 1'b0;
    m_nss   = 1'b0;
    wait_h();
    rxb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      cur = frm[i/8];
      m_bit(cur[7 - (i % 8)], collide && (i == nbits - 1), so);
      rxb = {rxb[6:0], so};
      if (i >= 8 && (i % 8) == 7 && i < eff && !h0[7]) got_sdo.push_back(int'(rxb));
    end
    if (!collide) begin
      wait_h();
      m_nss = 1'b1;
    end
    repeat (12) @(negedge clk);
    chk("sdo_en_in_frame", en_seen, (eff >= 8 && !h0[7]));
  endtask

  initial begin
    int nd, full, r;
    logic so;
    logic [7:0] cur;
    reset_n = 1'b0;
    m_sck = 1'b0;
    m_nss = 1'b1;
    m_sdi = 1'b0;
    sel   = 0;
    repeat (3) @(negedge clk);
    chk("rst_csr_read", rd0, 0);
    chk("rst_csr_write", wr0, 0);
    chk("rst_frame_abort", ab0, 0);
    chk("rst_sdo", sdo0, 0);
    chk("rst_sdo_en", sdo_en0, 0);
    chk("rst_chip_select", cs0, 0);
    chk("rst_csr_address", addr0, 0);
    chk("rst_csr_writedata", wd0, 0);
    chk("rst_chip_select_m3", cs1, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Mode 0 write frame with auto increment
    frm = '{8'h85, 8'hA5, 8'h3C};
    run_frame(24, 1'b0);
    // Read frame wrapping 31 -> 0
    frm = '{8'h1F, 8'h00, 8'hFF, 8'h5A};
    run_frame(32, 1'b0);
    // Abort after 4 bits of the second data byte
    frm = '{8'h85, 8'hA5, 8'h5A};
    run_frame(20, 1'b0);
    // nss rises together with the 8th sample edge of the data byte
    frm = '{8'h84, 8'h77};
    run_frame(16, 1'b1);

    // Reset mid read byte: header read already issued, nothing afterwards
    frm = '{8'h03, 8'hC6};
    exp_rd.push_back('{0, 3, 0});
    m_nss = 1'b0;
    wait_h();
    for (int i = 0; i < 12; i++) begin
      cur = frm[i/8];
      m_bit(cur[7 - (i % 8)], 1'b0, so);
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_sdo_en", sdo_en0, 0);
    chk("midrst_sdo", sdo0, 0);
    chk("midrst_csr_read", rd0, 0);
    chk("midrst_csr_write", wr0, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 12; i < 16; i++) begin
      cur = frm[i/8];
      m_bit(cur[7 - (i % 8)], 1'b0, so);
    end
    wait_h();
    m_nss = 1'b1;
    repeat (12) @(negedge clk);
    frm = '{8'h87, 8'h5A};
    run_frame(16, 1'b0);

    // Mode 3, fixed address
    set_sel(1);
    frm = '{8'h82, 8'h11, 8'h22};
    run_frame(24, 1'b0);

    // Randomised frames across both instances
    repeat (30) begin
      set_sel(int'($urandom_range(0, 1)));
      nd = int'($urandom_range(0, 3));
      frm.delete();
      for (int i = 0; i <= nd; i++) frm.push_back(8'($urandom));
      full = 8 * (nd + 1);
      r = int'($urandom_range(0, 9));
      if (r < 2) run_frame(int'($urandom_range(0, full - 1)), 1'b0);
      else if (r == 2) run_frame(full, 1'b1);
      else run_frame(full, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    chk("pending_aborts", exp_ab.size(), 0);
    chk("pending_sdo_bytes", exp_sdo.size(), 0);
    chk("sdo_or_strobe_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_csr_bridge.md
SPI_CSR_BRIDGE -- requirements
Module: spi_csr_bridge

Interface
REQ-001 SHALL have parameter A_WIDTH, default 5, CSR address width, legal range 1..7.
REQ-002 SHALL have parameter CPOL, default 0, sck idle level.
REQ-003 SHALL have parameter CPHA, default 0, sample edge: 0 = leading, 1 = trailing.
REQ-004 SHALL have parameter AUTO_INC, default 1, address increment per data byte: 1 = increment, 0 = fixed.
REQ-005 SHALL have port clk  in  1  system clock, the only clock; sck and nss are sampled in this domain.
REQ-006 SHALL have port reset_n  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports sck, nss, sdi  in  1 each  raw SPI pins, asynchronous to clk.
REQ-008 SHALL have port sdo  out  1  serial data, MSB first.
REQ-009 SHALL have port sdo_en  out  1  pad output enable for sdo.
REQ-010 SHALL have port chip_select  out  1  synchronised inverted nss.
REQ-011 SHALL have port csr_address  out  A_WIDTH  CSR address.
REQ-012 SHALL have ports csr_read and csr_write  out  1 each  single-clk request strobes.
REQ-013 SHALL have port csr_writedata  out  8  write data.
REQ-014 SHALL have port csr_readdata  in  8  read data, valid the clk after csr_read.
REQ-015 SHALL have port frame_abort  out  1  one-clk pulse when nss rises mid-byte.

Function
REQ-016 SHALL pass sck, nss and sdi through 2-flop synchronisers, then detect sample and shift edges from the synchronised sck per CPOL/CPHA; f_clk >= 8*f_sck is the supported operating range.
REQ-017 SHALL implement states IDLE, HEADER and DATA: IDLE->HEADER on synchronised nss low; HEADER->DATA after the 8th sample edge; any state->IDLE on synchronised nss high.
REQ-018 SHALL decode the header byte MSB-first: bit7 = 1 is a write frame, 0 is a read frame; bits[A_WIDTH-1:0] load csr_address; the remaining bits are ignored.
REQ-019 SHALL count bits 0..7 with a 3-bit counter, wrap to 0 after each byte, and clear it on entry to IDLE.
REQ-020 Write frame: SHALL update csr_writedata and pulse csr_write exactly 1 clk after the 8th sample edge of each data byte.
REQ-021 Write frame: after each csr_write, SHALL increment csr_address by 1 modulo 2^A_WIDTH when AUTO_INC=1.
REQ-022 Read frame: SHALL pulse csr_read 1 clk after the header's 8th sample edge and 1 clk after each data byte's 8th sample edge.
REQ-023 Read frame: SHALL capture csr_readdata into the transmit shift register on the clk following csr_read, and shift it out MSB-first on the next byte's shift edges (with CPHA=0, bit7 is presented immediately on load).
REQ-024 Read frame: after each csr_read, SHALL post-increment csr_address modulo 2^A_WIDTH when AUTO_INC=1, so it prefetches the next byte.
REQ-025 SHALL assert sdo_en only in DATA state of a read frame with chip_select high, and SHALL drive sdo 0 whenever sdo_en is low.
REQ-026 On nss rising with bit counter != 0, SHALL pulse frame_abort, drop the partial byte, and issue no csr_write; a csr_read already issued is not retracted.
REQ-027 SHALL emit no csr_read or csr_write for a frame that ends during HEADER.
REQ-028 Simultaneous nss rise and 8th sample edge: the nss rise SHALL win; the byte is discarded and frame_abort pulses.
REQ-029 csr_read and csr_write SHALL never be asserted in the same clk.

Reset
REQ-030 On reset_n low, SHALL immediately force: state IDLE; csr_read, csr_write, frame_abort, sdo and sdo_en = 0; chip_select = 0; csr_address = 0; csr_writedata = 0; synchronisers to the idle levels (nss = 1, sck = CPOL).
REQ-031 Reset asserted mid-frame SHALL abort without pulsing frame_abort; after reset release, the bridge SHALL wait for a fresh nss falling edge.

Structure
REQ-032 SHALL place the state encoding and the header bit position (WR_BIT = 7) in shared package spi_pkg.
REQ-033 SHALL instantiate sub-module spi_edge_sync once, containing the synchronisers and the sample/shift edge detector.

Verification
REQ-034 Scenario: mode 0, frame 0x85,0xA5,0x3C -> csr_write at addr 5 with 0xA5, then at addr 6 with 0x3C; sdo_en stays 0.
REQ-035 Scenario: read frame 0x1F, AUTO_INC=1, A_WIDTH=5, readdata = addr+0x40, 3 data bytes -> sdo bytes 0x5F,0x40,0x41; address wraps 31->0.
REQ-036 Scenario: nss rises after 4 bits of the second data byte -> exactly 1 csr_write and 1 frame_abort pulse.
REQ-037 Scenario: CPOL=1, CPHA=1, AUTO_INC=0, write 0x82,0x11,0x22 -> both writes at addr 2.
REQ-038 Scenario: reset_n pulsed low mid-read-byte -> sdo_en and sdo 0 at once, no strobes; the next frame decodes correctly.
REQ-039 Scenario: nss rises on the same clk as the 8th sample edge -> no csr_write, frame_abort = 1.
